// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detect controller.
// A host loads pattern/length/target/overlap, arms the block with start, and
// the block scans a qualified serial stream, pulsing match on every hit and
// raising done once the requested number of matches has been seen.
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [$clog2(PAT_W):0]   cfg_len,
    input  logic [CNT_W-1:0]         cfg_target,
    input  logic                     cfg_overlap,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     din,
    input  logic                     din_valid,
    output logic                     match,
    output logic [CNT_W-1:0]         match_count,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg,   state_next;
    logic [PAT_W-1:0]   pat_reg,     pat_next;
    logic [LEN_W-1:0]   len_reg,     len_next;
    logic [CNT_W-1:0]   target_reg,  target_next;
    logic               overlap_reg, overlap_next;
    // Only PAT_W-1 past bits are kept: together with the incoming bit they
    // form the full PAT_W-bit window that a pattern can span.
    logic [PAT_W-2:0]   hist_reg,    hist_next;
    logic [LEN_W-1:0]   fill_reg,    fill_next;
    logic               match_reg,   match_next;
    logic [CNT_W-1:0]   count_reg,   count_next;
    logic               err_reg,     err_next;

    logic [PAT_W-1:0]   hist_shift;
    logic [PAT_W-1:0]   len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic [CNT_W-1:0]   count_inc;
    logic               hit;
    logic               cfg_legal;
    logic               transfer;

    // Mask selecting the low len_reg bits of the window for comparison.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_len_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    assign hist_shift = {hist_reg, din};
    assign fill_inc   = fill_reg + 1'b1;
    assign fill_sat   = (fill_inc >= len_reg) ? len_reg : fill_inc;
    assign hit        = (fill_sat == len_reg) &&
                        (((hist_shift ^ pat_reg) & len_mask) == '0);
    assign count_inc  = count_reg + 1'b1;
    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W)) &&
                        (cfg_target != '0);
    assign transfer   = cfg_valid && (state_reg != SCAN);

    // State and datapath registers; reset returns to an unconfigured IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            len_reg     <= '0;
            target_reg  <= '0;
            overlap_reg <= 1'b0;
            hist_reg    <= '0;
            fill_reg    <= '0;
            match_reg   <= 1'b0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pat_reg     <= pat_next;
            len_reg     <= len_next;
            target_reg  <= target_next;
            overlap_reg <= overlap_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            match_reg   <= match_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
        end
    end

    // Next-state: config handshake beats start; abort beats a hit in SCAN.
    always_comb begin
        state_next   = state_reg;
        pat_next     = pat_reg;
        len_next     = len_reg;
        target_next  = target_reg;
        overlap_next = overlap_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        count_next   = count_reg;
        match_next   = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            SCAN: begin
                if (abort) begin
                    state_next = ARMED;
                end else if (din_valid) begin
                    hist_next = hist_shift[PAT_W-2:0];
                    fill_next = fill_sat;
                    if (hit) begin
                        match_next = 1'b1;
                        count_next = count_inc;
                        if (!overlap_reg) begin
                            hist_next = '0;
                            fill_next = '0;
                        end
                        if (count_inc == target_reg) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            default: begin
                if (transfer) begin
                    if (cfg_legal) begin
                        pat_next     = cfg_pattern;
                        len_next     = cfg_len;
                        target_next  = cfg_target;
                        overlap_next = cfg_overlap;
                        count_next   = '0;
                        state_next   = ARMED;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (start) begin
                    if (state_reg == IDLE) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = SCAN;
                        hist_next  = '0;
                        fill_next  = '0;
                        count_next = '0;
                    end
                end
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy      = (state_reg == SCAN);
        done      = (state_reg == DONE);
        cfg_ready = (state_reg != SCAN);
    end

    assign match       = match_reg;
    assign match_count = count_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: each step drives one cycle of stimulus,
// queues the hand-derived expected outputs, and compares after the edge.
module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [PAT_W-1:0]   cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               cfg_overlap = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               err;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string tag;
        logic  m;
        int    c;
        logic  b;
        logic  d;
        logic  e;
    } exp_t;

    exp_t sb[$];

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    endtask

    // One clock of stimulus; expected outputs are those after this edge.
    task automatic step(input logic cv, input logic st, input logic ab,
                        input logic d, input logic dv,
                        input logic em, input int ec,
                        input logic eb, input logic ed, input logic ee,
                        input string tag);
        exp_t e;
        exp_t got;
        cfg_valid = cv;
        start     = st;
        abort     = ab;
        din       = d;
        din_valid = dv;
        e.tag = tag; e.m = em; e.c = ec; e.b = eb; e.d = ed; e.e = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        got = sb.pop_front();
        chk(got.tag, "match",     32'(match),       32'(got.m));
        chk(got.tag, "count",     32'(match_count), 32'(got.c));
        chk(got.tag, "busy",      32'(busy),        32'(got.b));
        chk(got.tag, "done",      32'(done),        32'(got.d));
        chk(got.tag, "err",       32'(err),         32'(got.e));
        chk(got.tag, "cfg_ready", 32'(cfg_ready),   32'(!got.b));
        $display("%-16s match=%0b count=%0d busy=%0b done=%0b err=%0b cfg_ready=%0b",
                 got.tag, match, match_count, busy, done, err, cfg_ready);
    endtask

    task automatic set_cfg(input logic [PAT_W-1:0] p, input int len,
                           input int tgt, input logic ov);
        cfg_pattern = p;
        cfg_len     = LEN_W'(len);
        cfg_target  = CNT_W'(tgt);
        cfg_overlap = ov;
    endtask

    initial begin
        // cv st ab d dv | m cnt b d e
        rst = 1'b1;
        step(0,0,0,0,0, 0,0,0,0,0, "reset0");
        step(0,0,0,0,0, 0,0,0,0,0, "reset1");
        rst = 1'b0;

        // Illegal config and start from IDLE, then cfg+start together.
        set_cfg(8'b101, 0, 4, 1'b1);
        step(1,0,0,0,0, 0,0,0,0,1, "cfg_len0");
        step(0,1,0,0,0, 0,0,0,0,1, "start_idle");
        step(0,0,0,0,0, 0,0,0,0,0, "idle_quiet");
        set_cfg(8'b101, 3, 4, 1'b1);
        step(1,1,0,0,0, 0,0,0,0,0, "cfg_and_start");
        set_cfg(8'b101, 3, 0, 1'b1);
        step(1,0,0,0,0, 0,0,0,0,1, "cfg_tgt0");
        set_cfg(8'b101, 9, 4, 1'b1);
        step(1,0,0,0,0, 0,0,0,0,1, "cfg_len9");

        // Overlapping scan of 1,0,1,0,1 with the retained 101/len3/tgt4 cfg.
        step(0,1,0,0,0, 0,0,1,0,0, "A_start");
        step(0,0,0,1,1, 0,0,1,0,0, "A_b1");
        step(0,0,0,0,1, 0,0,1,0,0, "A_b2");
        step(0,0,0,1,1, 1,1,1,0,0, "A_hit1");
        step(0,1,0,0,1, 0,1,1,0,0, "A_start_ign");
        step(0,0,0,1,1, 1,2,1,0,0, "A_hit2");
        step(0,0,1,0,0, 0,2,0,0,0, "A_abort");

        // Non-overlapping: history clears after the first hit.
        set_cfg(8'b101, 3, 4, 1'b0);
        step(1,0,0,0,0, 0,0,0,0,0, "B_cfg");
        step(0,1,0,0,0, 0,0,1,0,0, "B_start");
        step(0,0,0,1,1, 0,0,1,0,0, "B_b1");
        step(0,0,0,0,1, 0,0,1,0,0, "B_b2");
        step(0,0,0,1,1, 1,1,1,0,0, "B_hit");
        step(0,0,0,0,1, 0,1,1,0,0, "B_b4");
        step(0,0,0,1,1, 0,1,1,0,0, "B_no_overlap");
        step(0,0,1,0,0, 0,1,0,0,0, "B_abort");

        // Target 2: DONE after the second hit, then din ignored, then rescan.
        set_cfg(8'b101, 3, 2, 1'b1);
        step(1,0,0,0,0, 0,0,0,0,0, "C_cfg");
        step(0,1,0,0,0, 0,0,1,0,0, "C_start");
        step(0,0,0,1,1, 0,0,1,0,0, "C_b1");
        step(0,0,0,0,1, 0,0,1,0,0, "C_b2");
        step(0,0,0,1,1, 1,1,1,0,0, "C_hit1");
        step(0,0,0,0,1, 0,1,1,0,0, "C_b4");
        step(0,0,0,1,1, 1,2,0,1,0, "C_done");
        step(0,0,0,0,1, 0,2,0,1,0, "C_b6");
        step(0,0,0,1,1, 0,2,0,1,0, "C_din_ign");
        step(0,1,0,0,0, 0,0,1,0,0, "C_rescan");

        // Qualifier gaps carry a 1 that would break the match if sampled.
        step(0,0,0,1,1, 0,0,1,0,0, "D_v1");
        step(0,0,0,1,0, 0,0,1,0,0, "D_gap1");
        step(0,0,0,0,1, 0,0,1,0,0, "D_v2");
        step(0,0,0,1,0, 0,0,1,0,0, "D_gap2");
        step(0,0,0,1,1, 1,1,1,0,0, "D_hit");
        step(0,0,0,1,0, 0,1,1,0,0, "D_gap3");

        // Abort on the completing bit: no match, count held, back to ARMED.
        step(0,0,0,0,1, 0,1,1,0,0, "E_b0");
        step(0,0,1,1,1, 0,1,0,0,0, "E_abort_hit");

        // Length-1 pattern: back-to-back match pulses.
        set_cfg(8'b1, 1, 3, 1'b1);
        step(1,0,0,0,0, 0,0,0,0,0, "L1_cfg");
        step(0,1,0,0,0, 0,0,1,0,0, "L1_start");
        step(0,0,0,1,1, 1,1,1,0,0, "L1_hit1");
        step(0,0,0,1,1, 1,2,1,0,0, "L1_hit2");
        step(0,0,0,1,1, 1,3,0,1,0, "L1_done");

        // Reset in the middle of a scan loses the configuration.
        step(0,1,0,0,0, 0,0,1,0,0, "F_start");
        step(0,0,0,0,1, 0,0,1,0,0, "F_b0");
        rst = 1'b1;
        step(0,0,0,1,1, 0,0,0,0,0, "F_rst");
        rst = 1'b0;
        step(0,1,0,0,0, 0,0,0,0,1, "F_start_refused");
        step(0,0,0,0,0, 0,0,0,0,0, "F_idle");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable serial pattern-detect controller.
- Accepts a configuration: pattern, pattern length, target match count and overlap mode.
- Arms on start, scans a qualified serial bit stream and pulses on every match.
- Counts matches and signals done when the target count is reached; sits between a host/config master and a serial data source.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
cfg_len  in  $clog2(PAT_W)+1  pattern length, legal 1..PAT_W
cfg_target  in  CNT_W  matches required for done, legal >=1
cfg_overlap  in  1  1: overlapping matches allowed; 0: history cleared after a match
start  in  1  begin scan
abort  in  1  stop scan
din  in  1  serial data bit
din_valid  in  1  din qualifier
match  out  1  one-cycle match pulse
match_count  out  CNT_W  matches in current/last scan
busy  out  1  high in SCAN
done  out  1  high in DONE
err  out  1  one-cycle error pulse

Behaviour:
- Reset (sync, highest priority): state=IDLE; stored cfg=0; history=0; fill=0; match=0; match_count=0; done=0; err=0. busy=0 and cfg_ready=1 follow from IDLE.
- States: IDLE (no valid cfg), ARMED (cfg held), SCAN, DONE. busy=(SCAN); done=(DONE); cfg_ready=(state!=SCAN).
- Config handshake: transfer = cfg_valid & cfg_ready.
  - Legal transfer: latch cfg, clear match_count, go to ARMED.
  - Illegal transfer (cfg_len==0, cfg_len>PAT_W or cfg_target==0): err=1 for one cycle; cfg and state unchanged.
- start: in ARMED or DONE, go to SCAN and clear history, fill and match_count.
  - start in IDLE: err pulse, no state change.
  - start in SCAN: ignored.
  - cfg transfer has priority over start in the same cycle; start is then ignored.
- SCAN, per clock with din_valid=1:
  - hist_n={hist[PAT_W-2:0],din}.
  - fill_n=min(fill+1,cfg_len).
  - hit = (fill_n==cfg_len) & (hist_n[cfg_len-1:0]==cfg_pattern[cfg_len-1:0]).
- din_valid=0: history, fill and outputs hold; match=0.
- On hit, at the same edge:
  - match<=1; visible the cycle after the completing sample.
  - match_count<=match_count+1.
  - If cfg_overlap=0: hist and fill clear to 0 instead of taking hist_n/fill_n.
  - If match_count+1==cfg_target: go to DONE.
- match is a one-cycle pulse; back-to-back pulses are legal when overlap=1 (e.g. len=1).
- DONE: din ignored; match_count held. start rescans with the same cfg; a legal cfg moves to ARMED.
- abort: in SCAN, go to ARMED on the next edge and suppress any hit that edge (no match, no count). match_count holds its pre-abort value. abort outside SCAN is ignored. abort has priority over hit.
- Widths: match_count never exceeds cfg_target, so no wrap is possible.
- rst mid-SCAN: cfg is lost and IDLE is entered; start is then refused with err.

Test Plan:
- cfg pattern=3'b101, len=3, target=4, overlap=1; start; din 1,0,1,0,1 (valid every cycle) -> match after bits 3 and 5; match_count=2; busy=1.
- Same stream with overlap=0 -> single match after bit 3; match_count=1; bits 4–5 ("01") give no match.
- pattern=101, len=3, target=2, overlap=1, din 1,0,1,0,1,0,1 -> done=1, busy=0 after bit 5; bit 7 gives no match; match_count stays 2; start -> SCAN with match_count=0.
- din_valid toggled 1,0,1,0,... with bits 1,x,0,x,1 -> match exactly once, after the third valid bit; gap cycles have no effect.
- cfg_len=0 with cfg_valid in IDLE -> err pulse, state IDLE. Then start -> err pulse, busy stays 0. Then legal cfg plus start in the same cycle -> ARMED only.
- abort on the cycle a completing bit arrives -> no match, count unchanged, ARMED. Separately, rst mid-SCAN -> all outputs 0, cfg_ready=1.
